// File: rtl/pulse_to_level.sv
// pulse_to_level: queues single-cycle events and emits one held high level per event; define PULSE_TO_LEVEL_ACK_EN to gate level exit on level_ack.
module pulse_to_level #(
    parameter int MIN_HIGH_CYCLES = 4,
    parameter int PENDING_WIDTH   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     input_pulse,
    input  logic                     level_ack,
    output logic                     output_level,
    output logic [PENDING_WIDTH-1:0] pending_count,
    output logic                     overflow
);
    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
    localparam logic [7:0] HOLD_INIT = 8'(MIN_HIGH_CYCLES - 1);
    localparam logic [PENDING_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [PENDING_WIDTH-1:0] PEND_ONE = PENDING_WIDTH'(1);
    state_t     state;
    logic [7:0] hold;
    logic       start, dec, inc, hold_exit;
    assign start = state == IDLE && (pending_count != '0 || input_pulse);
    assign dec   = state == IDLE && pending_count != '0;
    assign inc   = input_pulse && !(state == IDLE && pending_count == '0);
`ifdef PULSE_TO_LEVEL_ACK_EN
    logic ack_seen;
    assign hold_exit = hold == 8'd0 && (ack_seen || level_ack);
`else
    logic unused_ack;
    assign unused_ack = level_ack;
    assign hold_exit  = hold == 8'd0;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            hold          <= 8'd0;
            output_level  <= 1'b0;
            pending_count <= '0;
            overflow      <= 1'b0;
`ifdef PULSE_TO_LEVEL_ACK_EN
            ack_seen      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state        <= HIGH;
                    hold         <= HOLD_INIT;
                    output_level <= 1'b1;
`ifdef PULSE_TO_LEVEL_ACK_EN
                    ack_seen     <= 1'b0;
`endif
                end
                HIGH: begin
                    if (hold != 8'd0) hold <= hold - 8'd1;
`ifdef PULSE_TO_LEVEL_ACK_EN
                    ack_seen <= ack_seen | level_ack;
`endif
                    if (hold_exit) begin
                        state        <= GAP;
                        output_level <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // a pulse arriving while the queue is full and not draining is dropped
            if (inc && !dec) begin
                if (pending_count == PEND_MAX) overflow <= 1'b1;
                else pending_count <= pending_count + PEND_ONE;
            end else if (dec && !inc) begin
                pending_count <= pending_count - PEND_ONE;
            end
        end
    end
endmodule

// File: tb/tb_pulse_to_level.sv
// tb_pulse_to_level: scoreboard bench for pulse_to_level (MIN_HIGH_CYCLES=4, PENDING_WIDTH=2).
module tb_pulse_to_level;
`ifdef PULSE_TO_LEVEL_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       input_pulse = 1'b0;
    logic       level_ack = 1'b0;
    logic       output_level;
    logic [1:0] pending_count;
    logic       overflow;
    logic [3:0] sb[$];
    logic [3:0] got, exp;
    int         vectors = 0;
    int         errors = 0;

    pulse_to_level #(.MIN_HIGH_CYCLES(4), .PENDING_WIDTH(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .input_pulse(input_pulse),
        .level_ack(level_ack),
        .output_level(output_level),
        .pending_count(pending_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n = 1'b0;
        input_pulse = 1'b0;
        level_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        got = {output_level, pending_count, overflow};
        vectors++;
        if (got !== 4'b0) begin errors++; $display("FAIL reset_state got %b exp 0000", got); end
        for (int c = 1; c <= 28; c++) sb.push_back(c <= 13 ? {1'(c >= 11), 2'(c >= 13 ? 2 : c >= 12 ? 1 : 0), 1'b0} : 4'b0);
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            got = {output_level, pending_count, overflow};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin errors++; $display("FAIL reset_pre c=%0d got %b exp %b", c, got, exp); end
            input_pulse = (c >= 10 && c <= 12);
            level_ack = 1'b1;
        end
        #2 reset_n = 1'b0;
        #1 got = {output_level, pending_count, overflow};
        vectors++;
        if (got !== 4'b0) begin errors++; $display("FAIL reset_async got %b exp 0000", got); end
        #1 reset_n = 1'b1;
        for (int c = 14; c <= 28; c++) begin
            @(posedge clk); #1;
            got = {output_level, pending_count, overflow};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin errors++; $display("FAIL reset_post c=%0d got %b exp %b", c, got, exp); end
        end
    endtask

    task automatic test_ack_tied();
        do_reset();
        for (int c = 1; c <= 20; c++) sb.push_back({1'(c >= 11 && c <= 14), 2'd0, 1'b0});
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            got = {output_level, pending_count, overflow};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin errors++; $display("FAIL ack_tied c=%0d got %b exp %b", c, got, exp); end
            input_pulse = (c == 10);
            level_ack = 1'b1;
        end
    endtask

    task automatic test_ack_late();
        do_reset();
        for (int c = 1; c <= 25; c++) sb.push_back({1'(c >= 11 && c <= (ACK_EN ? 20 : 14)), 2'd0, 1'b0});
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            got = {output_level, pending_count, overflow};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin errors++; $display("FAIL ack_late c=%0d got %b exp %b", c, got, exp); end
            input_pulse = (c == 10);
            level_ack = (c == 20);
        end
    endtask

    task automatic test_ack_early();
        do_reset();
        for (int c = 1; c <= 20; c++) sb.push_back({1'(c >= 11 && c <= 14), 2'd0, 1'b0});
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            got = {output_level, pending_count, overflow};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin errors++; $display("FAIL ack_early c=%0d got %b exp %b", c, got, exp); end
            input_pulse = (c == 10);
            level_ack = (c == 12);
        end
    endtask

    task automatic test_no_ack();
        do_reset();
        for (int c = 1; c <= 20; c++) sb.push_back({1'(c >= 11 && (ACK_EN || c <= 14)), 2'd0, 1'b0});
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            got = {output_level, pending_count, overflow};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin errors++; $display("FAIL no_ack c=%0d got %b exp %b", c, got, exp); end
            input_pulse = (c == 10);
            level_ack = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 1; c <= 30; c++)
            sb.push_back({1'(c >= 11 && c <= 26 && (c - 11) % 6 < 4), 2'(c >= 12 && c <= 22 ? 1 : 0), 1'b0});
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            got = {output_level, pending_count, overflow};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin errors++; $display("FAIL back_to_back c=%0d got %b exp %b", c, got, exp); end
            input_pulse = (c == 10 || c == 11 || c == 16);
            level_ack = 1'b1;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 1; c <= 40; c++)
            sb.push_back({1'(c >= 11 && c <= 32 && (c - 11) % 6 < 4),
                          2'(c < 12 ? 0 : c == 12 ? 1 : c == 13 ? 2 : c <= 16 ? 3 : c <= 22 ? 2 : c <= 28 ? 1 : 0),
                          1'(c >= 15)});
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            got = {output_level, pending_count, overflow};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin errors++; $display("FAIL overflow c=%0d got %b exp %b", c, got, exp); end
            input_pulse = (c >= 10 && c <= 14);
            level_ack = 1'b1;
        end
        #2 reset_n = 1'b0;
        #1 vectors++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b exp 0", overflow); end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ack_tied();
        test_ack_late();
        test_ack_early();
        test_no_ack();
        test_back_to_back();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
